// File: rtl/rr_pkg.sv
// Shared constants and types for the rename-stage free list.
// Holds the default sizing of the physical register file and the
// checkpoint request record used by the free list top level.
package rr_pkg;

    localparam int unsigned P_REGISTERS = 64;
    localparam int unsigned L_REGISTERS = 32;
    localparam int unsigned ALLOC_W     = 2;
    localparam int unsigned REL_W       = 2;
    localparam int unsigned C_NUM       = 4;
    localparam int unsigned PREG_W      = $clog2(P_REGISTERS);
    localparam int unsigned CKPT_ID_W   = (C_NUM > 1) ? $clog2(C_NUM) : 1;
    localparam int unsigned LANE_W      = (ALLOC_W > 1) ? $clog2(ALLOC_W) : 1;

    // Checkpoint save request after flush arbitration.
    typedef struct packed {
        logic                 valid;
        logic [CKPT_ID_W-1:0] id;
        logic [LANE_W-1:0]    lane;
    } ckpt_req_t;

endpackage

// File: rtl/fl_popcount_prefix.sv
// Per-lane prefix population count.
// Ports:
//   bits_i  - lane enable vector
//   excl_o  - per lane, number of set bits strictly below that lane
//   total_o - number of set bits in bits_i
module fl_popcount_prefix #(
    parameter  int unsigned W     = 2,
    localparam int unsigned CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]            bits_i,
    output logic [W-1:0][CNT_W-1:0] excl_o,
    output logic [CNT_W-1:0]        total_o
);

    logic [CNT_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < W; k++) begin
            excl_o[k] = acc;
            acc       = acc + CNT_W'(bits_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/rr_free_list_ckpt.sv
// Physical register free list with branch checkpoints.
// Circular buffer of free pregs; head advances on allocation, tail on
// release. Checkpoints capture the head so a flush returns every
// speculatively allocated preg in a single cycle.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   alloc_req_i       - per-lane allocation request (contiguous from lane 0)
//   alloc_grant_o     - all requested lanes granted
//   alloc_preg_o      - allocated preg per lane (lane 0 in the low bits)
//   ckpt_save_i/id/lane - save head position after the branch's lane
//   rel_valid_i/preg  - pregs returned from commit
//   flush_valid_i/rat_id - restore head from a checkpoint
//   free_count_o      - number of free pregs
//   empty_lt_alloc_o  - fewer than ALLOC_W pregs free
module rr_free_list_ckpt #(
    parameter  int unsigned P_REGISTERS = rr_pkg::P_REGISTERS,
    parameter  int unsigned L_REGISTERS = rr_pkg::L_REGISTERS,
    parameter  int unsigned ALLOC_W     = rr_pkg::ALLOC_W,
    parameter  int unsigned REL_W       = rr_pkg::REL_W,
    parameter  int unsigned C_NUM       = rr_pkg::C_NUM,
    localparam int unsigned FREE_DEPTH  = P_REGISTERS - L_REGISTERS,
    localparam int unsigned PREG_W      = $clog2(P_REGISTERS),
    localparam int unsigned IDX_W       = $clog2(FREE_DEPTH),
    localparam int unsigned PTR_W       = IDX_W + 1,
    localparam int unsigned ID_W        = (C_NUM > 1) ? $clog2(C_NUM) : 1,
    localparam int unsigned LANE_W      = (ALLOC_W > 1) ? $clog2(ALLOC_W) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ALLOC_W-1:0]        alloc_req_i,
    output logic                      alloc_grant_o,
    output logic [ALLOC_W*PREG_W-1:0] alloc_preg_o,
    input  logic                      ckpt_save_i,
    input  logic [ID_W-1:0]           ckpt_id_i,
    input  logic [LANE_W-1:0]         ckpt_lane_i,
    input  logic [REL_W-1:0]          rel_valid_i,
    input  logic [REL_W*PREG_W-1:0]   rel_preg_i,
    input  logic                      flush_valid_i,
    input  logic [ID_W-1:0]           flush_rat_id_i,
    output logic [PTR_W-1:0]          free_count_o,
    output logic                      empty_lt_alloc_o
);

    localparam int unsigned ACNT_W = $clog2(ALLOC_W + 1);
    localparam int unsigned RCNT_W = $clog2(REL_W + 1);

    if ((FREE_DEPTH & (FREE_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FREE_DEPTH must be a power of two");
    end

    logic [PREG_W-1:0] mem_q [FREE_DEPTH];
    logic [PREG_W-1:0] mem_d [FREE_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]  ckpt_q [C_NUM];
    logic [PTR_W-1:0]  ckpt_d [C_NUM];

    logic [ALLOC_W-1:0][ACNT_W-1:0] alloc_excl;
    logic [ACNT_W-1:0]              alloc_n, alloc_incl;
    logic [REL_W-1:0][RCNT_W-1:0]   rel_excl;
    logic [RCNT_W-1:0]              rel_n;
    rr_pkg::ckpt_req_t              ckpt_req;

    fl_popcount_prefix #(.W(ALLOC_W)) u_alloc_cnt (
        .bits_i  (alloc_req_i),
        .excl_o  (alloc_excl),
        .total_o (alloc_n)
    );

    fl_popcount_prefix #(.W(REL_W)) u_rel_cnt (
        .bits_i  (rel_valid_i),
        .excl_o  (rel_excl),
        .total_o (rel_n)
    );

    assign free_count_o     = tail_q - head_q;
    assign empty_lt_alloc_o = free_count_o < PTR_W'(ALLOC_W);
    assign alloc_grant_o    = (alloc_n != '0) && (free_count_o >= PTR_W'(alloc_n))
                              && !flush_valid_i;

    // Allocations up to and including the branch's own lane belong before the checkpoint.
    assign alloc_incl = alloc_excl[ckpt_lane_i] + ACNT_W'(alloc_req_i[ckpt_lane_i]);

    // A flush in the same cycle wins over the save.
    assign ckpt_req = '{valid: ckpt_save_i && !flush_valid_i, id: ckpt_id_i, lane: ckpt_lane_i};

    always_comb begin
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_preg_o[i*PREG_W +: PREG_W] = mem_q[head_q[IDX_W-1:0] + IDX_W'(i)];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < REL_W; k++) begin
            if (rel_valid_i[k]) begin
                mem_d[tail_q[IDX_W-1:0] + IDX_W'(rel_excl[k])] = rel_preg_i[k*PREG_W +: PREG_W];
            end
        end
        tail_d = tail_q + PTR_W'(rel_n);

        head_d = head_q;
        if (flush_valid_i) begin
            head_d = ckpt_q[flush_rat_id_i];
        end else if (alloc_grant_o) begin
            head_d = head_q + PTR_W'(alloc_n);
        end

        ckpt_d = ckpt_q;
        if (ckpt_req.valid) begin
            ckpt_d[ckpt_req.id] = alloc_grant_o ? head_q + PTR_W'(alloc_incl) : head_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                mem_q[i] <= PREG_W'(L_REGISTERS + i);
            end
            for (int c = 0; c < C_NUM; c++) begin
                ckpt_q[c] <= '0;
            end
            head_q <= '0;
            tail_q <= PTR_W'(FREE_DEPTH);
        end else begin
            mem_q  <= mem_d;
            ckpt_q <= ckpt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifndef SYNTHESIS
    logic [PTR_W:0]       fill_after_rel;
    logic [PTR_W-1:0]     restore_dist;
    logic [ALLOC_W-1:0]   req_plus1;

    assign fill_after_rel = (PTR_W+1)'(free_count_o) + (PTR_W+1)'(rel_n);
    assign restore_dist   = tail_q - ckpt_q[flush_rat_id_i];
    assign req_plus1      = alloc_req_i + ALLOC_W'(1);

    a_rel_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        fill_after_rel <= (PTR_W+1)'(FREE_DEPTH));
    a_req_contig : assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_req_i & req_plus1) == '0);
    a_restore_dist : assert property (@(posedge clk) disable iff (!rst_n)
        flush_valid_i |-> restore_dist <= PTR_W'(FREE_DEPTH));
`endif

endmodule

// File: tb/tb_rr_free_list_ckpt.sv
module tb_rr_free_list_ckpt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alloc_req;
    logic        alloc_grant;
    logic [11:0] alloc_preg;
    logic        ckpt_save;
    logic [1:0]  ckpt_id;
    logic        ckpt_lane;
    logic [1:0]  rel_valid;
    logic [11:0] rel_preg;
    logic        flush_valid;
    logic [1:0]  flush_rat_id;
    logic [5:0]  free_count;
    logic        empty_lt_alloc;

    rr_free_list_ckpt u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_req_i      (alloc_req),
        .alloc_grant_o    (alloc_grant),
        .alloc_preg_o     (alloc_preg),
        .ckpt_save_i      (ckpt_save),
        .ckpt_id_i        (ckpt_id),
        .ckpt_lane_i      (ckpt_lane),
        .rel_valid_i      (rel_valid),
        .rel_preg_i       (rel_preg),
        .flush_valid_i    (flush_valid),
        .flush_rat_id_i   (flush_rat_id),
        .free_count_o     (free_count),
        .empty_lt_alloc_o (empty_lt_alloc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] relv, input int r0,
                         input int r1, input logic fl, input int flid, input logic sv,
                         input int sid, input int slane);
        alloc_req    = req;
        rel_valid    = relv;
        rel_preg     = {6'(r1), 6'(r0)};
        flush_valid  = fl;
        flush_rat_id = 2'(flid);
        ckpt_save    = sv;
        ckpt_id      = 2'(sid);
        ckpt_lane    = 1'(slane);
    endtask

    task automatic do_reset();
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive on the falling edge, sample 1 time unit later.
    task automatic cyc(input logic [1:0] req, input logic [1:0] relv, input int r0,
                       input int r1, input logic fl, input int flid, input logic sv,
                       input int sid, input int slane);
        @(negedge clk);
        drive(req, relv, r0, r1, fl, flid, sv, sid, slane);
        #1;
    endtask

    typedef struct {
        logic [1:0] req;
        logic [1:0] relv;
        int         r0;
        logic       fl;
        int         flid;
        logic       sv;
        int         sid;
        int         slane;
        logic       g;
        int         p0;
        int         p1;
        int         free;
    } vec_t;

    vec_t vecs[9];

    typedef struct {
        int seq;
        int preg;
    } inf_t;

    inf_t inflight[$];
    int   m_mem[32];
    int   m_ckpt[4];
    int   m_head, m_tail;

    logic [1:0] rq, rm;
    logic       fl, sv, exp_g;
    int         n, fid, sid, slane, c, front, rcnt, exp_free, incl, rp0, rp1, wr;
    int         rp[2];

    initial begin
        vecs[0] = '{2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 32, 33, 32};
        vecs[1] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30};
        vecs[2] = '{2'b11, 2'b00, 0, 0, 0, 1, 1, 0, 1, 34, 35, 30};
        vecs[3] = '{2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 36, 37, 28};
        vecs[4] = '{2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 26};
        vecs[5] = '{2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 35, 36, 29};
        vecs[6] = '{2'b11, 2'b01, 9, 1, 1, 0, 0, 0, 0, 0, 0, 27};
        vecs[7] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30};
        vecs[8] = '{2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1, 35, 36, 30};

        // Reset state
        do_reset();
        #1;
        check("reset_free", int'(free_count), 32);
        check("reset_empty", int'(empty_lt_alloc), 0);
        check("reset_grant", int'(alloc_grant), 0);

        // Table: basic alloc, checkpoint, flush, flush with release
        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].req, vecs[i].relv, vecs[i].r0, 0, vecs[i].fl, vecs[i].flid,
                vecs[i].sv, vecs[i].sid, vecs[i].slane);
            check($sformatf("vec%0d_grant", i), int'(alloc_grant), int'(vecs[i].g));
            check($sformatf("vec%0d_free", i), int'(free_count), vecs[i].free);
            if (vecs[i].g) begin
                check($sformatf("vec%0d_p0", i), int'(alloc_preg[5:0]), vecs[i].p0);
                check($sformatf("vec%0d_p1", i), int'(alloc_preg[11:6]), vecs[i].p1);
            end
        end

        // Drain to one free, all-or-nothing refusal, then exhaust
        do_reset();
        for (int i = 0; i < 15; i++) cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("drain_p62", int'(alloc_preg[5:0]), 62);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("one_free_count", int'(free_count), 1);
        check("one_free_empty", int'(empty_lt_alloc), 1);
        check("one_free_nogrant", int'(alloc_grant), 0);
        cyc(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("last_grant", int'(alloc_grant), 1);
        check("last_p0", int'(alloc_preg[5:0]), 63);
        // Release at empty: not allocatable in the same cycle
        cyc(2'b01, 2'b11, 5, 7, 0, 0, 0, 0, 0);
        check("empty_free", int'(free_count), 0);
        check("empty_nobypass", int'(alloc_grant), 0);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("rel_free", int'(free_count), 2);
        check("rel_grant", int'(alloc_grant), 1);
        check("rel_p0", int'(alloc_preg[5:0]), 5);
        check("rel_p1", int'(alloc_preg[11:6]), 7);
        cyc(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("rel_after_free", int'(free_count), 0);

        // Async reset in the middle of a flush
        do_reset();
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 1, 2, 1);
        for (int i = 0; i < 10; i++) cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b11, 2'b00, 0, 0, 1, 2, 0, 0, 0);
        check("pre_rst_free", int'(free_count), 10);
        check("pre_rst_grant", int'(alloc_grant), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_free", int'(free_count), 32);
        check("mid_rst_empty", int'(empty_lt_alloc), 0);
        @(negedge clk);
        drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_free", int'(free_count), 32);
        cyc(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_p0", int'(alloc_preg[5:0]), 32);
        check("post_rst_p1", int'(alloc_preg[11:6]), 33);
        cyc(2'b00, 2'b00, 0, 0, 1, 2, 0, 0, 0);
        check("post_rst_pre_flush", int'(free_count), 30);
        cyc(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_ckpt_cleared", int'(free_count), 32);

        // Randomised traffic against an in-order free/in-flight model
        do_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
        for (int i = 0; i < 4; i++) m_ckpt[i] = 0;
        m_head = 0;
        m_tail = 32;
        inflight.delete();
        for (int cy = 0; cy < 1500; cy++) begin
            n  = $urandom_range(0, 2);
            rq = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            rm = 2'($urandom_range(0, 3));
            rcnt = int'(rm[0]) + int'(rm[1]);
            if (rcnt > inflight.size()) rm = 2'b00;
            rp[0] = 0;
            rp[1] = 0;
            for (int k = 0; k < 2; k++) begin
                if (rm[k]) begin
                    rp[k] = inflight[0].preg;
                    void'(inflight.pop_front());
                end
            end
            fl  = 1'b0;
            fid = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                c     = m_ckpt[fid];
                front = (inflight.size() != 0) ? inflight[0].seq : m_head;
                if (c <= m_head && c >= front) fl = 1'b1;
            end
            sv    = ($urandom_range(0, 3) == 0);
            sid   = $urandom_range(0, 3);
            slane = $urandom_range(0, 1);

            cyc(rq, rm, rp[0], rp[1], fl, fid, sv, sid, slane);
            exp_free = m_tail - m_head;
            exp_g    = (n > 0) && (exp_free >= n) && !fl;
            check("rnd_grant", int'(alloc_grant), int'(exp_g));
            check("rnd_free", int'(free_count), exp_free);
            check("rnd_empty", int'(empty_lt_alloc), int'(exp_free < 2));
            if (exp_g) begin
                check("rnd_p0", int'(alloc_preg[5:0]), m_mem[m_head % 32]);
                if (n == 2) check("rnd_p1", int'(alloc_preg[11:6]), m_mem[(m_head + 1) % 32]);
            end

            if (exp_g) begin
                for (int i = 0; i < n; i++)
                    inflight.push_back('{seq: m_head + i, preg: m_mem[(m_head + i) % 32]});
            end
            if (sv && !fl) begin
                incl = int'(rq[0]) + ((slane == 1) ? int'(rq[1]) : 0);
                m_ckpt[sid] = exp_g ? m_head + incl : m_head;
            end
            wr = 0;
            for (int k = 0; k < 2; k++) begin
                if (rm[k]) begin
                    m_mem[(m_tail + wr) % 32] = rp[k];
                    wr++;
                end
            end
            m_tail += wr;
            if (fl) begin
                m_head = m_ckpt[fid];
                while (inflight.size() != 0 && inflight[$].seq >= m_head)
                    void'(inflight.pop_back());
            end else if (exp_g) begin
                m_head += n;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
